uart_rx_buffer_ctrl: RTL and testbench
======================================

Name: uart_rx_buffer_ctrl

Overview:
- Parametrised receive-side buffer and flow-control stage for the UART.
- Sits between the UART receiver (which delivers frame data and error flags) and the APB register interface.
- Stores data plus per-entry parity/stop error flags in a DEPTH-entry FIFO, or in a 1-entry holding register when the FIFO is disabled.
- Also generates:
  - a programmable trigger flag;
  - RTS with hysteresis;
  - a sticky overrun flag;
  - a character-timeout indication.

Parameters:
- DATA_W, 8: frame data width (5..9 supported).
- DEPTH, 16: FIFO entries; power of 2, at least 4.
- TO_W, 12: width of the tick counter and of char_ticks_i.
- TIMEOUT_CHARS, 4: idle character times before timeout_o asserts.
- RTS_HYST, 2: entries below the trigger level at which RTS is released.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- rx_en_i  in  1  receive enable; gates push.
- fifo_en_i  in  1  1 = FIFO mode, 0 = single holding register.
- fifo_reset_i  in  1  synchronous flush.
- tick_i  in  1  baud-oversample tick.
- char_ticks_i  in  TO_W  ticks per character frame.
- rx_data_i  in  DATA_W  received frame data.
- rx_valid_i  in  1  one-cycle frame-done strobe.
- rx_parity_err_i  in  1  parity error for the frame, qualified by rx_valid_i.
- rx_stop_err_i  in  1  stop-bit error for the frame, qualified by rx_valid_i.
- pop_i  in  1  one-cycle read strobe.
- trig_level_i  in  $clog2(DEPTH)+1  trigger level.
- hf_en_i  in  1  hardware flow control enable.
- force_rts_i  in  1  force RTS to ready.
- clr_overrun_i  in  1  clear sticky overrun.
- cnt_clr_i  in  1  clear error counters.
- data_o  out  DATA_W  popped data.
- data_valid_o  out  1  pop result strobe.
- parity_err_o  out  1  parity error of the popped entry.
- stop_err_o  out  1  stop error of the popped entry.
- empty_o  out  1  buffer empty.
- full_o  out  1  buffer full.
- level_o  out  $clog2(DEPTH)+1  current occupancy.
- triggered_o  out  1  level at or above trigger.
- overrun_o  out  1  sticky overrun flag.
- timeout_o  out  1  character timeout.
- rts_no  out  1  0 = ready to receive, 1 = stop.
- parity_err_cnt_o  out  16  parity error count.
- stop_err_cnt_o  out  16  stop error count.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - all outputs 0 except empty_o=1;
  - pointers, counters and tick counter cleared.
- Capacity: CAP = DEPTH when fifo_en_i=1, otherwise 1. level_o ranges 0..CAP.
- full_o = (level==CAP); empty_o = (level==0).
- Push:
  - condition: rx_valid_i & rx_en_i.
  - If not full: store {parity, stop, data} at the write pointer; level+1.
  - If full and no pop: frame dropped, contents unchanged, overrun_o set.
- Pop:
  - pop_i & ~empty: data_o and the error flags load the head entry on the next edge; data_valid_o=1 for exactly 1 cycle; level-1.
  - Latency is 1 clk. pop_i while empty is ignored; data_o holds its value.
- Push and pop in the same cycle:
  - If full: both happen, no overrun, level unchanged.
  - If empty: pop ignored, push stored.
  - Otherwise: both happen, level unchanged.
- Pointers wrap modulo DEPTH.
- overrun_o is sticky; cleared by clr_overrun_i or a flush. If set and clear occur in the same cycle, set wins.
- Flush:
  - fifo_reset_i, or any change of fifo_en_i (edge detected on a registered copy), flushes: pointers=0, level=0, overrun and timeout cleared.
  - data_o is kept.
  - Flush has priority over push and pop in the same cycle.
- Trigger:
  - trig_eff = clamp(trig_level_i, 1, CAP).
  - triggered_o = level_o >= trig_eff (combinational from the registered level).
- RTS:
  - hf_en_i=0 or force_rts_i=1 gives rts_no=0 on the next edge.
  - Otherwise set rts_no=1 when level >= trig_eff.
  - Clear rts_no when level < trig_eff-RTS_HYST, saturating at 0; i.e. clear only at level 0 if trig_eff <= RTS_HYST.
  - Otherwise rts_no holds.
- Timeout (FIFO mode only):
  - The TO_W+3-bit counter increments on tick_i while non-empty and no push or pop occurs.
  - The counter resets to 0 on push, pop, empty, flush or fifo_en_i=0, and saturates at all-ones.
  - timeout_o=1 while counter >= char_ticks_i*TIMEOUT_CHARS (compare at full product width).
  - char_ticks_i=0 disables timeout.

Optional Feature:
- Macro: UART_RX_ERR_CNT_EN.
- Defined:
  - Saturating 16-bit counters increment on each accepted push with the matching error flag set; dropped frames do not count.
  - cnt_clr_i zeroes both counters; clear has priority over increment.
- Undefined: both count outputs tied 0, cnt_clr_i ignored, no counter flops.

Test Plan:
- FIFO mode, DEPTH=16: push 0x11..0x20 (16 frames), then push 0x55 -> full_o=1, overrun_o=1, 16 pops return 0x11..0x20 in order, each with data_valid_o one cycle after pop_i.
- trig_level_i=8, hf_en_i=1: push 8 -> rts_no=1. Pop to level 6 -> rts_no still 1. Pop to level 5 -> rts_no=0. force_rts_i=1 at level 10 -> rts_no=0.
- Full FIFO with push and pop in the same cycle -> level stays 16, no overrun, the new frame is the last popped. Empty FIFO with push and pop in the same cycle -> level=1, no data_valid_o.
- char_ticks_i=160, one frame pushed, tick_i every cycle -> timeout_o rises on cycle 640 after the push. A pop clears it next cycle, and empty_o=1.
- fifo_en_i=0: push 0xA5 with parity error, push 0x3C -> overrun_o=1. Pop -> data_o=0xA5, parity_err_o=1. Toggling fifo_en_i -> level_o=0, overrun_o=0.
- With UART_RX_ERR_CNT_EN: 3 pushes with stop error, 1 dropped with stop error -> stop_err_cnt_o=3. cnt_clr_i -> 0.

Source files
------------

// File: rtl/uart_rx_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_buffer_ctrl
// Brief    : UART receive buffer (FIFO or 1-entry holding register) with
//            trigger, RTS hysteresis, sticky overrun and character timeout.
//            Optional error counters: define UART_RX_ERR_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_buffer_ctrl #(
  parameter int DATA_W        = 8,
  parameter int DEPTH         = 16,
  parameter int TO_W          = 12,
  parameter int TIMEOUT_CHARS = 4,
  parameter int RTS_HYST      = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rx_en_i,
  input  logic                     fifo_en_i,
  input  logic                     fifo_reset_i,
  input  logic                     tick_i,
  input  logic [TO_W-1:0]          char_ticks_i,
  input  logic [DATA_W-1:0]        rx_data_i,
  input  logic                     rx_valid_i,
  input  logic                     rx_parity_err_i,
  input  logic                     rx_stop_err_i,
  input  logic                     pop_i,
  input  logic [$clog2(DEPTH):0]   trig_level_i,
  input  logic                     hf_en_i,
  input  logic                     force_rts_i,
  input  logic                     clr_overrun_i,
  input  logic                     cnt_clr_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     data_valid_o,
  output logic                     parity_err_o,
  output logic                     stop_err_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     triggered_o,
  output logic                     overrun_o,
  output logic                     timeout_o,
  output logic                     rts_no,
  output logic [15:0]              parity_err_cnt_o,
  output logic [15:0]              stop_err_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = TO_W + 3;
  localparam int PW = TO_W + 32;

  logic [DATA_W+1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              r_fifo_en_q;
  logic [CW-1:0]     r_to_cnt;

  logic [LW-1:0]     w_cap, w_trig_eff, w_rel;
  logic              w_flush, w_push_req, w_pop_req, w_do_push;
  logic              w_full, w_empty, w_ovr_set, w_rts_clear;
  logic [PW-1:0]     w_to_lim;

  assign w_cap      = fifo_en_i ? LW'(DEPTH) : LW'(1);
  assign w_full     = (r_level == w_cap);
  assign w_empty    = (r_level == '0);
  assign w_flush    = fifo_reset_i | (fifo_en_i != r_fifo_en_q);
  assign w_push_req = rx_valid_i & rx_en_i;
  assign w_pop_req  = pop_i & ~w_empty;
  // A full buffer still accepts a frame when a pop frees the head slot.
  assign w_do_push  = w_push_req & (~w_full | w_pop_req);
  assign w_ovr_set  = w_push_req & w_full & ~w_pop_req;

  always_comb begin
    w_trig_eff = trig_level_i;
    if (trig_level_i == '0)
      w_trig_eff = LW'(1);
    else if (trig_level_i > w_cap)
      w_trig_eff = w_cap;
    w_rel = '0;
    if (w_trig_eff > LW'(RTS_HYST))
      w_rel = w_trig_eff - LW'(RTS_HYST);
  end

  // Release threshold saturates at 0, meaning release only when empty.
  assign w_rts_clear = (w_rel == '0) ? w_empty : (r_level < w_rel);

  assign empty_o     = w_empty;
  assign full_o      = w_full;
  assign level_o     = r_level;
  assign triggered_o = (r_level >= w_trig_eff);

  always_ff @(posedge clk) begin
    if (reset_n && !w_flush && w_do_push)
      r_mem[r_wr_ptr] <= {rx_parity_err_i, rx_stop_err_i, rx_data_i};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fifo_en_q  <= fifo_en_i;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      overrun_o    <= 1'b0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      parity_err_o <= 1'b0;
      stop_err_o   <= 1'b0;
    end else begin
      r_fifo_en_q  <= fifo_en_i;
      data_valid_o <= 1'b0;
      if (w_flush) begin
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_level   <= '0;
        overrun_o <= 1'b0;
      end else begin
        if (w_do_push)
          r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop_req) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          {parity_err_o, stop_err_o, data_o} <= r_mem[r_rd_ptr];
          data_valid_o <= 1'b1;
        end
        if (w_do_push && !w_pop_req)
          r_level <= r_level + 1'b1;
        else if (!w_do_push && w_pop_req)
          r_level <= r_level - 1'b1;
        if (w_ovr_set)
          overrun_o <= 1'b1;
        else if (clr_overrun_i)
          overrun_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      rts_no <= 1'b0;
    else if (!hf_en_i || force_rts_i)
      rts_no <= 1'b0;
    else if (r_level >= w_trig_eff)
      rts_no <= 1'b1;
    else if (w_rts_clear)
      rts_no <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_to_cnt <= '0;
    else if (w_flush || !fifo_en_i || w_empty || w_push_req || w_pop_req)
      r_to_cnt <= '0;
    else if (tick_i && (r_to_cnt != '1))
      r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign w_to_lim  = PW'(char_ticks_i) * PW'(TIMEOUT_CHARS);
  assign timeout_o = fifo_en_i & (char_ticks_i != '0) & (PW'(r_to_cnt) >= w_to_lim);

`ifdef UART_RX_ERR_CNT_EN
  logic [15:0] r_par_cnt, r_stp_cnt;
  logic        w_cnt_push;

  // Only frames actually stored are counted; dropped frames are not.
  assign w_cnt_push = w_do_push & ~w_flush;

  always_ff @(posedge clk) begin
    if (!reset_n || cnt_clr_i) begin
      r_par_cnt <= '0;
      r_stp_cnt <= '0;
    end else if (w_cnt_push) begin
      if (rx_parity_err_i && (r_par_cnt != 16'hFFFF))
        r_par_cnt <= r_par_cnt + 1'b1;
      if (rx_stop_err_i && (r_stp_cnt != 16'hFFFF))
        r_stp_cnt <= r_stp_cnt + 1'b1;
    end
  end

  assign parity_err_cnt_o = r_par_cnt;
  assign stop_err_cnt_o   = r_stp_cnt;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr_i;
  assign parity_err_cnt_o = '0;
  assign stop_err_cnt_o   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_buffer_ctrl
// Brief    : Directed scoreboard bench for uart_rx_buffer_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_buffer_ctrl;

  logic        clk = 1'b0;
  logic        reset_n, rx_en_i, fifo_en_i, fifo_reset_i, tick_i;
  logic [11:0] char_ticks_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i, rx_parity_err_i, rx_stop_err_i, pop_i;
  logic [4:0]  trig_level_i;
  logic        hf_en_i, force_rts_i, clr_overrun_i, cnt_clr_i;
  logic [7:0]  data_o;
  logic        data_valid_o, parity_err_o, stop_err_o, empty_o, full_o;
  logic [4:0]  level_o;
  logic        triggered_o, overrun_o, timeout_o, rts_no;
  logic [15:0] parity_err_cnt_o, stop_err_cnt_o;

  always #5 clk = ~clk;

  uart_rx_buffer_ctrl dut (
    .clk(clk), .reset_n(reset_n), .rx_en_i(rx_en_i), .fifo_en_i(fifo_en_i),
    .fifo_reset_i(fifo_reset_i), .tick_i(tick_i), .char_ticks_i(char_ticks_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_parity_err_i(rx_parity_err_i), .rx_stop_err_i(rx_stop_err_i),
    .pop_i(pop_i), .trig_level_i(trig_level_i), .hf_en_i(hf_en_i),
    .force_rts_i(force_rts_i), .clr_overrun_i(clr_overrun_i),
    .cnt_clr_i(cnt_clr_i), .data_o(data_o), .data_valid_o(data_valid_o),
    .parity_err_o(parity_err_o), .stop_err_o(stop_err_o), .empty_o(empty_o),
    .full_o(full_o), .level_o(level_o), .triggered_o(triggered_o),
    .overrun_o(overrun_o), .timeout_o(timeout_o), .rts_no(rts_no),
    .parity_err_cnt_o(parity_err_cnt_o), .stop_err_cnt_o(stop_err_cnt_o)
  );

  int          total = 0;
  int          bad   = 0;
  logic [9:0]  q[$];
  int          cap;
  logic        exp_ovr;
  logic [15:0] exp_pcnt, exp_scnt;
  logic [7:0]  last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_push(input logic [7:0] d, input logic p, input logic s);
    if (q.size() < cap) begin
      q.push_back({p, s, d});
`ifdef UART_RX_ERR_CNT_EN
      if (p && exp_pcnt != 16'hFFFF) exp_pcnt++;
      if (s && exp_scnt != 16'hFFFF) exp_scnt++;
`endif
    end else begin
      exp_ovr = 1'b1;
    end
  endtask

  task automatic push(input logic [7:0] d, input logic p, input logic s);
    rx_data_i = d; rx_parity_err_i = p; rx_stop_err_i = s; rx_valid_i = 1'b1;
    @(negedge clk);
    rx_valid_i = 1'b0; rx_parity_err_i = 1'b0; rx_stop_err_i = 1'b0;
    model_push(d, p, s);
  endtask

  task automatic check_pop(input string tag);
    logic [9:0] e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_dv"}, data_valid_o, 1);
      chk({tag, "_data"}, data_o, e[7:0]);
      chk({tag, "_perr"}, parity_err_o, e[9]);
      chk({tag, "_serr"}, stop_err_o, e[8]);
      last_data = e[7:0];
    end else begin
      chk({tag, "_dv_empty"}, data_valid_o, 0);
      chk({tag, "_hold"}, data_o, last_data);
    end
  endtask

  task automatic pop_chk(input string tag);
    pop_i = 1'b1;
    @(negedge clk);
    pop_i = 1'b0;
    check_pop(tag);
  endtask

  task automatic push_pop(input string tag, input logic [7:0] d);
    rx_data_i = d; rx_valid_i = 1'b1; pop_i = 1'b1;
    @(negedge clk);
    rx_valid_i = 1'b0; pop_i = 1'b0;
    check_pop(tag);
    model_push(d, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; rx_en_i = 1'b1; fifo_en_i = 1'b1; fifo_reset_i = 1'b0;
    tick_i = 1'b0; char_ticks_i = '0; rx_data_i = '0; rx_valid_i = 1'b0;
    rx_parity_err_i = 1'b0; rx_stop_err_i = 1'b0; pop_i = 1'b0;
    trig_level_i = 5'd8; hf_en_i = 1'b0; force_rts_i = 1'b0;
    clr_overrun_i = 1'b0; cnt_clr_i = 1'b0;
    cap = 16; exp_ovr = 1'b0; exp_pcnt = '0; exp_scnt = '0; last_data = '0;

    step(3);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_ovr", overrun_o, 0);
    chk("rst_dv", data_valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_rts", rts_no, 0);
    chk("rst_to", timeout_o, 0);
    chk("rst_trig", triggered_o, 0);
    chk("rst_pcnt", parity_err_cnt_o, 0);
    reset_n = 1'b1;
    step(1);

    // Fill, overflow, set-vs-clear overrun, drain in order
    for (int i = 0; i < 16; i++) push(8'h11 + 8'(i), 1'b0, 1'b0);
    chk("fill_full", full_o, 1);
    chk("fill_level", level_o, 16);
    chk("fill_trig", triggered_o, 1);
    chk("fill_ovr0", overrun_o, 0);
    push(8'h55, 1'b0, 1'b0);
    chk("ovr_set", overrun_o, exp_ovr);
    chk("ovr_level", level_o, 16);
    clr_overrun_i = 1'b1;
    push(8'h66, 1'b0, 1'b0);
    chk("ovr_set_wins", overrun_o, 1);
    step(1);
    clr_overrun_i = 1'b0;
    exp_ovr = 1'b0;
    chk("ovr_clr", overrun_o, exp_ovr);
    pop_chk("pop_first");
    step(1);
    chk("dv_one_cycle", data_valid_o, 0);
    while (q.size() > 0) pop_chk("drain1");
    chk("drain1_empty", empty_o, 1);
    pop_chk("pop_empty");
    chk("pop_empty_level", level_o, 0);

    // RTS hysteresis
    hf_en_i = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i), 1'b0, 1'b0);
    step(1);
    chk("rts_set8", rts_no, 1);
    pop_chk("rts_pop"); pop_chk("rts_pop");
    step(1);
    chk("rts_hold6", rts_no, 1);
    pop_chk("rts_pop");
    step(1);
    chk("rts_rel5", rts_no, 0);
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i), 1'b0, 1'b0);
    step(1);
    chk("rts_lvl10", rts_no, 1);
    force_rts_i = 1'b1;
    step(1);
    chk("rts_force", rts_no, 0);
    force_rts_i = 1'b0; hf_en_i = 1'b0;
    while (q.size() > 0) pop_chk("drain2");

    // Simultaneous push/pop at full and at empty
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i), 1'b0, 1'b0);
    push_pop("pp_full", 8'h99);
    chk("pp_full_level", level_o, 16);
    chk("pp_full_ovr", overrun_o, 0);
    while (q.size() > 0) pop_chk("drain3");
    push_pop("pp_empty", 8'h42);
    chk("pp_empty_level", level_o, 1);
    pop_chk("pp_empty_pop");

    // Character timeout
    char_ticks_i = 12'd160; tick_i = 1'b1; trig_level_i = 5'd0;
    push(8'h77, 1'b0, 1'b0);
    chk("trig_clamp_lo", triggered_o, 1);
    step(639);
    chk("to_before", timeout_o, 0);
    step(1);
    chk("to_rise", timeout_o, 1);
    pop_chk("to_pop");
    chk("to_clear", timeout_o, 0);
    chk("to_empty", empty_o, 1);
    tick_i = 1'b0; trig_level_i = 5'd8;

    // Holding-register mode
    fifo_en_i = 1'b0;
    step(1);
    q.delete(); cap = 1; exp_ovr = 1'b0;
    chk("hr_level0", level_o, 0);
    push(8'hA5, 1'b1, 1'b0);
    push(8'h3C, 1'b0, 1'b0);
    chk("hr_ovr", overrun_o, exp_ovr);
    chk("hr_full", full_o, 1);
    pop_chk("hr_pop");
    push(8'h3C, 1'b0, 1'b0);
    push(8'h5A, 1'b0, 1'b0);
    chk("hr_ovr2", overrun_o, 1);
    fifo_en_i = 1'b1;
    step(1);
    q.delete(); cap = 16; exp_ovr = 1'b0;
    chk("tog_level", level_o, 0);
    chk("tog_ovr", overrun_o, exp_ovr);
    chk("tog_keep_data", data_o, last_data);

    // Error counters
    for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i), 1'b0, 1'b1);
    for (int i = 0; i < 13; i++) push(8'hD0 + 8'(i), 1'b0, 1'b0);
    push(8'hEE, 1'b0, 1'b1);
    chk("cnt_stop", stop_err_cnt_o, exp_scnt);
    chk("cnt_par", parity_err_cnt_o, exp_pcnt);
    cnt_clr_i = 1'b1;
    step(1);
    cnt_clr_i = 1'b0;
    exp_pcnt = '0; exp_scnt = '0;
    chk("cnt_clr_stop", stop_err_cnt_o, exp_scnt);
    chk("cnt_clr_par", parity_err_cnt_o, exp_pcnt);
    chk("pre_flush_ovr", overrun_o, exp_ovr);
    fifo_reset_i = 1'b1;
    step(1);
    fifo_reset_i = 1'b0;
    q.delete(); exp_ovr = 1'b0;
    chk("flush_level", level_o, 0);
    chk("flush_empty", empty_o, 1);
    chk("flush_ovr", overrun_o, exp_ovr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
